// File: rtl/bus_responder_pkg.sv
// Shared constants and types for the bus responder: memory-map addresses,
// STATUS bit positions and the access FSM state encoding.
package bus_responder_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int TX_FIFO_DEPTH  = 4;

    localparam logic [15:0] ADDR_STATUS = 16'hFF00;
    localparam logic [15:0] ADDR_TXDATA = 16'hFF01;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/bus_responder_tx_fifo.sv
// Small power-of-two FIFO feeding the output port. A push while full is
// accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_responder.sv
// CPU-bus slave: IDLE/WAIT/DATA access FSM in front of an inferred RAM,
// a STATUS register and a TXDATA port backed by a small FIFO.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int RAM_AW      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] iodb,
    input  logic                  rw,
    input  logic [DATA_WIDTH-1:0] abl,
    input  logic [DATA_WIDTH-1:0] abh,
    output logic                  rdy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam int CW = 3;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_wait_cnt;
    logic [CW-1:0]         w_wait_cnt_next;
    logic [AW-1:0]         r_addr;
    logic                  r_rw_q;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_ram [2**RAM_AW];
    logic [DATA_WIDTH-1:0] r_ram_rd;

    logic [AW-1:0]         w_bus_addr;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic                  w_in_ram;
    logic                  w_is_status;
    logic                  w_is_txdata;
    logic                  w_data_end;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_bus_addr  = {abh, abl};
    assign w_in_ram    = (r_addr[AW-1:RAM_AW] == '0);
    assign w_is_status = (r_addr == AW'(ADDR_STATUS));
    assign w_is_txdata = (r_addr == AW'(ADDR_TXDATA));
    assign w_data_end  = (r_state == DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_rw_q     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_state == IDLE) begin
                r_addr <= w_bus_addr;
                r_rw_q <= rw;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        rdy             = 1'b0;
        case (r_state)
            IDLE: begin
                if (WAIT_STATES == 0) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next    = WAIT;
                    w_wait_cnt_next = CW'(WAIT_STATES - 1);
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = DATA;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 1'b1;
                end
            end
            DATA: begin
                rdy          = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // In IDLE the bus address is used directly so read data is ready even with no wait states.
    assign w_ram_idx = (r_state == IDLE) ? w_bus_addr[RAM_AW-1:0] : r_addr[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (w_data_end && r_rw_q && w_in_ram) begin
            r_ram[r_addr[RAM_AW-1:0]] <= iodb;
        end
        r_ram_rd <= r_ram[w_ram_idx];
    end

    assign w_push   = w_data_end && r_rw_q && w_is_txdata;
    assign w_pop    = tx_ready && tx_valid;
    assign tx_valid = !w_empty;

    tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_push      (w_push),
        .i_push_data (iodb),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (tx_data)
    );

    // A dropped push outranks the clear-on-read of STATUS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_data_end && !r_rw_q && w_is_status) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_OVF_BIT]   = r_ovf;
    end

    always_comb begin
        if (w_in_ram) begin
            w_rd_data = r_ram_rd;
        end else if (w_is_status) begin
            w_rd_data = w_status;
        end else begin
            w_rd_data = '1;
        end
    end

    assign iodb = (w_data_end && !r_rw_q) ? w_rd_data : 'z;

endmodule
